// File: rtl/sw_debounce_pkg.sv
// +--------------------------------------------------------------------------+
// | sw_debounce_pkg : shared types and constants for the button debouncer    |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

package sw_debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } ch_state_e;

  // Bit positions of each button within btn_raw / btn_level.
  localparam int BTN_N = 0;
  localparam int BTN_E = 1;
  localparam int BTN_S = 2;
  localparam int BTN_W = 3;

endpackage

`default_nettype wire

// File: rtl/sw_debounce_ch.sv
// +--------------------------------------------------------------------------+
// | sw_debounce_ch : one-bit synchroniser, stability counter and press FSM   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module sw_debounce_ch
  import sw_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rstn,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= RELEASED;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;

    // Any disagreement with the pending level restarts the window from zero.
    unique case (state_q)
      RELEASED: begin
        if (sync2_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync2_q) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = PRESSED;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!sync2_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (sync2_q) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = RELEASED;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase

    level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
  end

  assign level = level_q;
  assign pulse = pulse_q;

endmodule

`default_nettype wire

// File: rtl/sw_debounce4.sv
// +--------------------------------------------------------------------------+
// | sw_debounce4 : four-button debouncer producing levels and press pulses   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module sw_debounce4
  import sw_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int ACTIVE_HIGH     = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] btn_raw,
  output logic       sw_n,
  output logic       sw_e,
  output logic       sw_s,
  output logic       sw_w,
  output logic [3:0] btn_level
);

  logic [3:0] raw_pressed;
  logic [3:0] pulse;

  // Normalise to "1 = pressed" ahead of the synchronisers.
  assign raw_pressed = (ACTIVE_HIGH != 0) ? btn_raw : ~btn_raw;

  for (genvar i = 0; i < 4; i++) begin : g_ch
    sw_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_ch (
      .clk   (clk),
      .rstn  (rstn),
      .raw   (raw_pressed[i]),
      .level (btn_level[i]),
      .pulse (pulse[i])
    );
  end

  assign sw_n = pulse[BTN_N];
  assign sw_e = pulse[BTN_E];
  assign sw_s = pulse[BTN_S];
  assign sw_w = pulse[BTN_W];

endmodule

`default_nettype wire

// File: tb/tb_sw_debounce4.sv
// +--------------------------------------------------------------------------+
// | tb_sw_debounce4 : self-checking bench for sw_debounce4 (both polarities) |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_sw_debounce4;

  localparam int D  = 8;
  localparam int CW = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] btn_raw = 4'h0;
  logic [3:0] btn_raw_inv = 4'hF;

  logic       sw_n, sw_e, sw_s, sw_w;
  logic [3:0] btn_level;
  logic       iv_n, iv_e, iv_s, iv_w;
  logic [3:0] iv_level;
  logic [3:0] pulses, iv_pulses;

  assign pulses    = {sw_w, sw_s, sw_e, sw_n};
  assign iv_pulses = {iv_w, iv_s, iv_e, iv_n};

  always #5 clk = ~clk;

  sw_debounce4 #(.DEBOUNCE_CYCLES(D), .CNT_W(CW), .ACTIVE_HIGH(1)) dut (
    .clk(clk), .rstn(rstn), .btn_raw(btn_raw),
    .sw_n(sw_n), .sw_e(sw_e), .sw_s(sw_s), .sw_w(sw_w), .btn_level(btn_level)
  );

  sw_debounce4 #(.DEBOUNCE_CYCLES(D), .CNT_W(CW), .ACTIVE_HIGH(0)) dut_inv (
    .clk(clk), .rstn(rstn), .btn_raw(btn_raw_inv),
    .sw_n(iv_n), .sw_e(iv_e), .sw_s(iv_s), .sw_w(iv_w), .btn_level(iv_level)
  );

  int tests = 0;
  int fails = 0;
  int first_p[4], cnt_p[4], first_fall[4];
  int iv_first[4], iv_cnt[4];
  int iv_total = 0;

  typedef struct {
    logic [3:0] raw;
    int         n;
    logic [3:0] exp_level;
    logic [3:0] exp_pulse;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Runs n clock edges; edge index 0 is the first edge that samples the
  // inputs applied just before the call.
  task automatic watch(input int n);
    for (int i = 0; i < 4; i++) begin
      first_p[i] = -1; cnt_p[i] = 0; first_fall[i] = -1;
      iv_first[i] = -1; iv_cnt[i] = 0;
    end
    for (int e = 0; e < n; e++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        if (pulses[i]) begin
          cnt_p[i]++;
          if (first_p[i] < 0) first_p[i] = e;
        end
        if (!btn_level[i] && first_fall[i] < 0) first_fall[i] = e;
        if (iv_pulses[i]) begin
          iv_cnt[i]++;
          iv_total++;
          if (iv_first[i] < 0) iv_first[i] = e;
        end
      end
    end
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{4'b0000,  5, 4'b0000, 4'b0000};
    vecs[1]  = '{4'b0001,  9, 4'b0000, 4'b0000};
    vecs[2]  = '{4'b0001,  2, 4'b0001, 4'b0001};
    vecs[3]  = '{4'b0001, 20, 4'b0001, 4'b0000};
    vecs[4]  = '{4'b0000,  9, 4'b0001, 4'b0000};
    vecs[5]  = '{4'b0000,  2, 4'b0000, 4'b0000};
    vecs[6]  = '{4'b1001, 11, 4'b1001, 4'b1001};
    vecs[7]  = '{4'b0000, 12, 4'b0000, 4'b0000};
    vecs[8]  = '{4'b0110, 12, 4'b0110, 4'b0110};
    vecs[9]  = '{4'b0100, 12, 4'b0100, 4'b0000};
    vecs[10] = '{4'b0000, 12, 4'b0000, 4'b0000};

    // Reset state
    #12;
    check("reset_pulses", int'(pulses), 0);
    check("reset_level", int'(btn_level), 0);
    check("reset_inv_level", int'(iv_level), 0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Table-driven phase
    for (int v = 0; v < 11; v++) begin
      logic [4:0] act;
      btn_raw = vecs[v].raw;
      watch(vecs[v].n);
      act = '0;
      for (int i = 0; i < 4; i++) begin
        act[i] = (cnt_p[i] == 1);
        if (cnt_p[i] > 1) act[4] = 1'b1;
      end
      check($sformatf("vec%0d_level", v), int'(btn_level), int'(vecs[v].exp_level));
      check($sformatf("vec%0d_pulse", v), int'(act), int'({1'b0, vecs[v].exp_pulse}));
    end

    // Bounce on south: 1,0,1,0 at 3-cycle intervals, then held
    begin
      int bounce_pulses = 0;
      for (int b = 0; b < 4; b++) begin
        btn_raw = (b % 2 == 0) ? 4'b0100 : 4'b0000;
        watch(3);
        bounce_pulses += cnt_p[0] + cnt_p[1] + cnt_p[2] + cnt_p[3];
      end
      check("bounce_no_pulse", bounce_pulses, 0);
      btn_raw = 4'b0100;
      watch(15);
      check("bounce_s_first", first_p[2], 10);
      check("bounce_s_count", cnt_p[2], 1);
      check("bounce_others", cnt_p[0] + cnt_p[1] + cnt_p[3], 0);
      btn_raw = 4'b0000;
      watch(12);
    end

    // Hold east for 100 cycles then release
    btn_raw = 4'b0010;
    watch(100);
    check("hold_e_count", cnt_p[1], 1);
    check("hold_e_first", first_p[1], 10);
    btn_raw = 4'b0000;
    watch(15);
    check("release_e_fall", first_fall[1], 10);
    check("release_e_nopulse", cnt_p[1], 0);

    // Simultaneous north + west
    btn_raw = 4'b1001;
    watch(12);
    check("simul_n_first", first_p[0], 10);
    check("simul_w_first", first_p[3], 10);
    check("simul_level", int'(btn_level), 9);
    btn_raw = 4'b0000;
    watch(12);

    // Reset mid-debounce with west already latched pressed
    btn_raw = 4'b1000;
    watch(12);
    check("pre_reset_level", int'(btn_level), 8);
    btn_raw = 4'b1001;
    watch(5);
    rstn = 1'b0;
    #1;
    check("async_reset_level", int'(btn_level), 0);
    check("async_reset_pulses", int'(pulses), 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    watch(12);
    check("post_reset_n_first", first_p[0], 10);
    check("post_reset_n_count", cnt_p[0], 1);
    check("post_reset_w_first", first_p[3], 10);
    check("post_reset_level", int'(btn_level), 9);
    btn_raw = 4'b0000;
    watch(12);

    // Active-low instance: idle-high inputs never pulse; west low presses
    check("inv_idle_pulses", iv_total, 0);
    check("inv_idle_level", int'(iv_level), 0);
    btn_raw_inv = 4'b0111;
    watch(12);
    check("inv_w_first", iv_first[3], 10);
    check("inv_w_count", iv_cnt[3], 1);
    check("inv_others", iv_cnt[0] + iv_cnt[1] + iv_cnt[2], 0);
    check("inv_level", int'(iv_level), 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sw_debounce4.md
Name: sw_debounce4

Overview:
- Front-end conditioner for the four board push-buttons (north, east, south, west).
- Sits directly upstream of the BRAM read/LED display block.
- Synchronises each raw, bouncing button input into the clk domain and debounces it.
- Per button, produces a clean level and a single-cycle press pulse; the pulse drives the display block's sw_n/sw_e/sw_s/sw_w inputs, so one physical press starts exactly one read.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised cycles required to accept a level change (10 ms at 100 MHz); legal range 2..2^CNT_W-1.
- CNT_W, 20, width of each per-channel stability counter.
- ACTIVE_HIGH, 1, 1: raw input high means pressed; 0: raw input low means pressed (inverted before the synchroniser).

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- btn_raw  in  4  raw button pins, bit0=N, bit1=E, bit2=S, bit3=W; asynchronous to clk.
- sw_n  out  1  one-cycle press pulse, north.
- sw_e  out  1  one-cycle press pulse, east.
- sw_s  out  1  one-cycle press pulse, south.
- sw_w  out  1  one-cycle press pulse, west.
- btn_level  out  4  debounced pressed level, same bit order as btn_raw.

Behaviour:
- Reset (rstn low, asynchronous): all synchroniser flops 0 (not pressed), all channels RELEASED, counters 0, sw_* = 0, btn_level = 0. Outputs must go to these values immediately, without waiting for a clk edge.
- Synchroniser: 2-flop synchroniser per bit, after the optional inversion. s[i] is the second flop's output.
- Channel FSM, one independent instance per bit:
  - RELEASED: if s=1, go to PRESS_WAIT with cnt<=0.
  - PRESS_WAIT: if s=0, return to RELEASED with cnt<=0. Else if cnt==DEBOUNCE_CYCLES-1, go to PRESSED and assert pulse for one cycle. Else cnt<=cnt+1.
  - PRESSED: if s=0, go to RELEASE_WAIT with cnt<=0.
  - RELEASE_WAIT: if s=1, return to PRESSED with cnt<=0. Else if cnt==DEBOUNCE_CYCLES-1, go to RELEASED (no pulse on release). Else cnt<=cnt+1.
- btn_level[i] is registered: 1 in PRESSED and RELEASE_WAIT, 0 otherwise.
- Press pulse is registered: high for exactly one cycle on entry to PRESSED, low in all other cycles.
- Latency: a raw rise first sampled at edge k (held clean) gives pulse and btn_level high after edge k+2+DEBOUNCE_CYCLES. Release is symmetric: btn_level falls after edge k+2+DEBOUNCE_CYCLES.
- Bounce: any glitch shorter than DEBOUNCE_CYCLES restarts the count. No pulse until a full clean window is seen.
- Holding a button produces no further pulses. There is no auto-repeat.
- Simultaneous presses: channels are fully independent, so several sw_* may pulse in the same cycle. Priority (N>E>S>W) is resolved downstream, not here.
- A pulse that arrives while the downstream block is busy is lost. This is accepted; no queuing.
- Reset mid-debounce discards the partial count. A button still held after rstn releases must complete a full window and then produces one pulse.
- Counter never exceeds DEBOUNCE_CYCLES-1. There is no wrap-around.

Decomposition:
- Shared package sw_debounce_pkg holds:
  - 2-bit state encodings RELEASED=0, PRESS_WAIT=1, PRESSED=2, RELEASE_WAIT=3;
  - button index constants BTN_N=0, BTN_E=1, BTN_S=2, BTN_W=3.
- Sub-module sw_debounce_ch: synchroniser, counter and FSM for one bit, with ports clk, rstn, raw, level, pulse, and parameters DEBOUNCE_CYCLES and CNT_W.
- The top instantiates sw_debounce_ch four times and maps pulse[3:0] onto sw_n/sw_e/sw_s/sw_w.

Test Plan (all cases use DEBOUNCE_CYCLES=8, CNT_W=4):
- Clean press: btn_raw[0] 0->1 at edge k and held -> sw_n high only in the cycle after edge k+10; btn_level[0]=1 from then on; sw_e/sw_s/sw_w stay 0.
- Bounce: btn_raw[2] toggles 1,0,1,0 at 3-cycle intervals, then held 1 -> exactly one sw_s pulse, 10 edges after the final rise; no pulse during the bounce.
- Hold and release: btn_raw[1] held 1 for 100 cycles then 0 -> exactly one sw_e pulse; btn_level[1] falls 10 edges after the release; no pulse on release.
- Simultaneous: btn_raw=4'b1001 applied at the same edge -> sw_n and sw_w pulse in the same cycle; btn_level=4'b1001.
- Reset mid-debounce: rstn low for 1 cycle, 5 cycles into a press, with the button still held -> all outputs 0 immediately; one sw_n pulse exactly 10 edges after the first edge with rstn high.
- Polarity: ACTIVE_HIGH=0 and btn_raw=4'b1111 idle -> no pulses; btn_raw[3]=0 held -> one sw_w pulse after 10 edges.
